key_schedule_seq: RTL
=====================

Name: key_schedule_seq

Overview:
- Sequential, runtime-configurable AES key expansion engine supporting AES-128, AES-192 and AES-256.
- Computes one 32-bit schedule word per clock using a single shared 4-byte S_Box bank, instead of fully unrolled combinational logic.
- Stores all round keys internally and serves them through an indexed, registered read port to the round datapath and SPI front end.

Parameters:
- MAX_NK, 8, largest supported key length in words; legal values 4, 6, 8. Sizes key width and storage depth.
- MAX_WORDS, 4*(MAX_NK+7), schedule word storage depth; 60 at default.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to expand key.
- key_size  in  2  2'b00 = 128, 2'b01 = 192, 2'b10 = 256, 2'b11 = 128.
- key  in  32*MAX_NK  cipher key; word i = key[32*i +: 32], MSB byte first within a word; unused upper words ignored.
- rk_idx  in  4  round key index to read, 0..Nr.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- key_ready  out  1  level: stored schedule is valid.
- nr  out  4  round count of the stored schedule: 10, 12 or 14.
- rk_out  out  128  registered round key {w[4r+3], w[4r+2], w[4r+1], w[4r]}.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done and key_ready = 0; nr = 0; rk_out = 0; all storage words, word counter and Rcon register cleared. A reset mid-expansion aborts it with no done pulse.
- FSM states:
  - IDLE: on start, latch key_size, derive Nk/Nr, go to LOAD; busy=1 from the next cycle.
  - LOAD: write w[0..Nk-1] from key in one cycle; i=Nk; rcon=8'h01; go to EXPAND.
  - EXPAND: each cycle, temp=w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon) (8'h80 -> 8'h1b).
    - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
    - Write w[i] = w[i-Nk] ^ temp; i++.
    - When i == 4*(Nr+1)-1 is written, go to FIN.
  - FIN: done=1 for one cycle, busy=0, key_ready=1, nr=Nr; return to IDLE.
- i mod Nk is tracked with a wrap counter, not a divider; exactly one S_Box bank is used, with its input muxed between RotWord(temp) and temp.
- Latency from the start-sampling edge to done high: 2 + (4*(Nr+1)-Nk) cycles, giving 42 (128), 48 (192) and 54 (256).
- start while busy: ignored. start in IDLE with key_ready=1: key_ready drops next cycle and the old schedule is overwritten.
- Read port:
  - rk_out updates one cycle after rk_idx is sampled.
  - rk_out = 0 while busy, while key_ready=0, or when rk_idx > nr.
- Changes to key or key_size after start is sampled have no effect on the running expansion.

Optional Feature:
- Macro: KEYSCHED_CACHE_EN.
  - Defined: a register holds the last fully expanded key and key_size. If start arrives with key_ready=1 and an identical key and key_size, the block skips LOAD/EXPAND: done pulses 1 cycle after start, key_ready stays 1, and busy stays 0. The cache is invalidated by reset or by any abort.
  - Undefined: every start performs a full expansion; no cache registers are instantiated.

Decomposition:
- Package aes_keysched_pkg:
  - key_size encodings.
  - Functions nk_of(size) and nr_of(size).
  - Constant MAX_WORDS.
  - The xtime function.
  - FSM state enum {IDLE, LOAD, EXPAND, FIN}.
- One natural sub-module, keysched_subword: 4 existing S_Box instances plus the RotWord/plain input mux, purely combinational. FSM and storage remain in the top module.

Test Plan:
- AES-128 (FIPS-197 A.1): key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c, key_size=00 -> done 42 cycles after start; rk_idx=10 gives rk_out words d014f9a8, c9ee2589, e13f0cc8, b6630ca6; nr=10.
- AES-192 (A.2): key 8e73b0f7 ... 522c6b7b, key_size=01 -> done at 48 cycles; w[51] = 01002202; nr=12.
- AES-256 (A.3): key 603deb10 ... 0914dff4, key_size=10 -> done at 54 cycles; w[59] = 706c631e; nr=14.
- Robustness:
  - start pulsed mid-EXPAND -> ignored; result unchanged.
  - rst_n low at cycle 20 -> busy=0, key_ready=0, rk_out=0, no done.
- Read edge cases: rk_idx=11 with an AES-128 schedule -> rk_out=0; reading during busy -> 0.
- KEYSCHED_CACHE_EN: repeat the A.1 start -> done 1 cycle later, busy never set. Change one key bit -> full 42-cycle run.

Source files
------------

// File: rtl/aes_keysched_pkg.sv
// rtl/aes_keysched_pkg.sv - shared encodings, sizing helpers and FSM states for the AES key schedule
package aes_keysched_pkg;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} ks_state_t;

    // 2'b11 falls back to AES-128
    function automatic logic [3:0] nk_of(input logic [1:0] size);
        case (size)
            KS_192:  nk_of = 4'd6;
            KS_256:  nk_of = 4'd8;
            default: nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] size);
        case (size)
            KS_192:  nr_of = 4'd12;
            KS_256:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map
module aes_sbox
    import aes_keysched_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    logic [7:0] inv;

    always_comb begin
        logic [7:0] sq;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/keysched_subword.sv
// rtl/keysched_subword.sv - single shared 4-byte S-box bank with optional RotWord on its input
module keysched_subword (
    input  logic [31:0] word,
    input  logic        rot,
    output logic [31:0] sub
);

    logic [31:0] sin;

    assign sin = rot ? {word[23:0], word[31:24]} : word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a(sin[8*b +: 8]),
            .y(sub[8*b +: 8])
        );
    end

endmodule

// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - one-word-per-clock AES-128/192/256 key expansion with indexed round-key read
// Optional: KEYSCHED_CACHE_EN skips re-expansion when the same key/size is requested again.
module key_schedule_seq #(
    parameter int MAX_NK    = 8,
    parameter int MAX_WORDS = 4 * (MAX_NK + 7)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_size,
    input  logic [32*MAX_NK-1:0]  key,
    input  logic [3:0]            rk_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  key_ready,
    output logic [3:0]            nr,
    output logic [127:0]          rk_out
);
    import aes_keysched_pkg::*;

    localparam int IW = $clog2(MAX_WORDS);

    ks_state_t             state;
    logic [3:0]            nk_q;
    logic [3:0]            nr_q;
    logic [IW-1:0]         i_q;
    logic [2:0]            kmod;
    logic [7:0]            rcon;
    logic [31:0]           w [MAX_WORDS];
    logic [32*MAX_NK-1:0]  key_q;
    logic [32*MAX_NK-1:0]  key_m;
    logic [31:0]           temp;
    logic [31:0]           sub;
    logic [31:0]           tword;
    logic [31:0]           wnew;
    logic [IW-1:0]         last_idx;
    logic                  cache_hit;

    // Words beyond Nk are zeroed so they never influence the cache compare
    always_comb begin
        key_m = '0;
        for (int k = 0; k < MAX_NK; k++)
            if (k < int'(nk_of(key_size))) key_m[32*k +: 32] = key[32*k +: 32];
    end

`ifdef KEYSCHED_CACHE_EN
    logic       cache_valid;
    logic [1:0] size_q;
    assign cache_hit = cache_valid && key_ready && (size_q == key_size) && (key_q == key_m);
`else
    assign cache_hit = 1'b0;
`endif

    assign last_idx = IW'({nr_q, 2'b11});

    keysched_subword u_subword (
        .word(temp),
        .rot (kmod == 3'd0),
        .sub (sub)
    );

    always_comb begin
        temp = w[i_q - IW'(1)];
        if (kmod == 3'd0)
            tword = sub ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && kmod == 3'd4)
            tword = sub;
        else
            tword = temp;
        wnew = w[i_q - IW'(nk_q)] ^ tword;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
            nr        <= 4'd0;
            rk_out    <= '0;
            nk_q      <= 4'd0;
            nr_q      <= 4'd0;
            i_q       <= '0;
            kmod      <= 3'd0;
            rcon      <= 8'h00;
            key_q     <= '0;
            for (int k = 0; k < MAX_WORDS; k++) w[k] <= 32'h0;
`ifdef KEYSCHED_CACHE_EN
            cache_valid <= 1'b0;
            size_q      <= 2'b00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (cache_hit) begin
                        done <= 1'b1;
                    end else begin
                        nk_q      <= nk_of(key_size);
                        nr_q      <= nr_of(key_size);
                        key_q     <= key_m;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
`ifdef KEYSCHED_CACHE_EN
                        cache_valid <= 1'b0;
                        size_q      <= key_size;
`endif
                    end
                end
                LOAD: begin
                    for (int k = 0; k < MAX_NK; k++)
                        if (4'(k) < nk_q) w[k] <= key_q[32*k +: 32];
                    i_q   <= IW'(nk_q);
                    kmod  <= 3'd0;
                    rcon  <= 8'h01;
                    state <= EXPAND;
                end
                EXPAND: begin
                    w[i_q] <= wnew;
                    i_q    <= i_q + IW'(1);
                    if (kmod == 3'd0) rcon <= xtime(rcon);
                    kmod <= (kmod == 3'(nk_q - 4'd1)) ? 3'd0 : kmod + 3'd1;
                    if (i_q == last_idx) state <= FIN;
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    key_ready <= 1'b1;
                    nr        <= nr_q;
                    state     <= IDLE;
`ifdef KEYSCHED_CACHE_EN
                    cache_valid <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase

            if (busy || !key_ready || rk_idx > nr)
                rk_out <= '0;
            else
                rk_out <= {w[{rk_idx, 2'd3}], w[{rk_idx, 2'd2}], w[{rk_idx, 2'd1}], w[{rk_idx, 2'd0}]};
        end
    end

endmodule
